// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller and its timeout counter.
package dmem_pkg;

  localparam int TIMEOUT_W = 16;

  // An all-zero byte mask never names a lane and is rejected like a misaligned access.
  localparam logic [3:0] MASK_NONE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  function automatic logic req_legal(input logic [1:0] addr_lo, input logic [3:0] mask);
    return (addr_lo == 2'b00) && (mask != MASK_NONE);
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Cycle counter for the bus WAIT phase; flags the last permitted cycle.
module dmem_timeout_ctr
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] TERMINAL = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = en && (count == TERMINAL);

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle load/store controller between the memory stage and a request/response bus.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy,
  output logic        o_bus_req_valid,
  input  logic        i_bus_req_ready,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_wen,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_mask,
  input  logic        i_bus_rsp_valid,
  input  logic [31:0] i_bus_rsp_rdata
);

  state_t      state;
  state_t      state_next;
  req_t        req_q;
  logic        stale;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        accept;
  logic        legal;
  logic        timed_out;

  assign accept = i_req_valid && o_req_ready;
  assign legal  = req_legal(i_req_addr[1:0], i_req_mask);

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (i_clk),
    .rst     (i_rst),
    .clr     ((state == REQ) && i_bus_req_ready),
    .en      (state == WAIT),
    .expired (timed_out)
  );

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = legal ? REQ : RESP;
      REQ:     if (i_bus_req_ready) state_next = WAIT;
      WAIT:    if (i_bus_rsp_valid || timed_out) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the request/bus registers are plain flops, so they are reset along with the FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      stale       <= 1'b0;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= state_next;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      if (accept) begin
        req_q <= '{addr: i_req_addr, wen: i_req_wen, wdata: i_req_wdata, mask: i_req_mask};
        if (!legal) rsp_err_q <= 1'b1;
      end
      // A real response wins over a coincident timeout; stores always return zero data.
      if (state == WAIT) begin
        if (i_bus_rsp_valid) begin
          rsp_rdata_q <= req_q.wen ? '0 : i_bus_rsp_rdata;
        end else if (timed_out) begin
          rsp_err_q <= 1'b1;
          stale     <= 1'b1;
        end
      end else if (stale && i_bus_rsp_valid) begin
        stale <= 1'b0;
      end
    end
  end

  assign o_req_ready     = (state == IDLE) && !stale;
  assign o_busy          = (state != IDLE);
  assign o_bus_req_valid = (state == REQ);
  assign o_rsp_valid     = (state == RESP);
  assign o_rsp_rdata     = rsp_rdata_q;
  assign o_rsp_err       = rsp_err_q;
  assign o_bus_addr      = req_q.addr;
  assign o_bus_wen       = req_q.wen;
  assign o_bus_wdata     = req_q.wdata;
  assign o_bus_mask      = req_q.mask;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scenario-driven bench for dmem_ctrl; responses are checked against a queue of expected results.
module tb_dmem_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;

  logic        i_clk;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_wen;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_mask;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_busy;
  logic        o_bus_req_valid;
  logic        i_bus_req_ready;
  logic [31:0] o_bus_addr;
  logic        o_bus_wen;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_mask;
  logic        i_bus_rsp_valid;
  logic [31:0] i_bus_rsp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  dmem_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_addr      (i_req_addr),
    .i_req_wen       (i_req_wen),
    .i_req_wdata     (i_req_wdata),
    .i_req_mask      (i_req_mask),
    .o_rsp_valid     (o_rsp_valid),
    .o_rsp_rdata     (o_rsp_rdata),
    .o_rsp_err       (o_rsp_err),
    .o_busy          (o_busy),
    .o_bus_req_valid (o_bus_req_valid),
    .i_bus_req_ready (i_bus_req_ready),
    .o_bus_addr      (o_bus_addr),
    .o_bus_wen       (o_bus_wen),
    .o_bus_wdata     (o_bus_wdata),
    .o_bus_mask      (o_bus_mask),
    .i_bus_rsp_valid (i_bus_rsp_valid),
    .i_bus_rsp_rdata (i_bus_rsp_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Every response pulse is matched against the oldest expected result.
  always @(negedge i_clk) begin
    if (!i_rst && o_rsp_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rsp got rdata=%h err=%b expected no response", o_rsp_rdata, o_rsp_err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (o_rsp_rdata !== e.rdata || o_rsp_err !== e.err) begin
          errors++;
          $display("FAIL sb_rsp got rdata=%h err=%b expected rdata=%h err=%b",
                   o_rsp_rdata, o_rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic drive_req(input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] mask);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    i_req_wen   = wen;
    i_req_wdata = wdata;
    i_req_mask  = mask;
  endtask

  task automatic release_req();
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_req_wen   = 1'b0;
    i_req_wdata = '0;
    i_req_mask  = '0;
  endtask

  // Zero-wait load: request at N, bus ready at N+1, bus data at N+2, response expected at N+3.
  task automatic run_load(input logic [31:0] addr, input logic [31:0] data, output int rsp_cyc);
    @(negedge i_clk);
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready addr=%h got=%b expected=1", addr, o_req_ready);
    end
    sb_q.push_back('{rdata: data, err: 1'b0});
    drive_req(addr, 1'b0, 32'h0, 4'hF);
    @(negedge i_clk);
    release_req();
    checks++;
    if ({o_busy, o_bus_req_valid, o_bus_wen} !== 3'b110 || o_bus_addr !== addr || o_bus_mask !== 4'hF) begin
      errors++;
      $display("FAIL load_bus_req busy=%b valid=%b wen=%b addr=%h mask=%h expected 1 1 0 %h f",
               o_busy, o_bus_req_valid, o_bus_wen, o_bus_addr, o_bus_mask, addr);
    end
    i_bus_req_ready = 1'b1;
    @(negedge i_clk);
    i_bus_req_ready = 1'b0;
    checks++;
    if ({o_busy, o_bus_req_valid, o_rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL load_wait busy/req_valid/rsp_valid got=%b expected=100",
               {o_busy, o_bus_req_valid, o_rsp_valid});
    end
    i_bus_rsp_valid = 1'b1;
    i_bus_rsp_rdata = data;
    @(negedge i_clk);
    i_bus_rsp_valid = 1'b0;
    i_bus_rsp_rdata = '0;
    rsp_cyc = cyc;
    checks++;
    if ({o_busy, o_rsp_valid} !== 2'b11) begin
      errors++;
      $display("FAIL load_rsp_timing busy/rsp_valid got=%b expected=11", {o_busy, o_rsp_valid});
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_req_ready, o_busy, o_rsp_valid, o_rsp_err, o_bus_req_valid, o_bus_wen} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b expected=100000",
               {o_req_ready, o_busy, o_rsp_valid, o_rsp_err, o_bus_req_valid, o_bus_wen});
    end
    checks++;
    if (o_rsp_rdata !== '0 || o_bus_addr !== '0 || o_bus_wdata !== '0 || o_bus_mask !== '0) begin
      errors++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h mask=%h expected all zero",
               o_rsp_rdata, o_bus_addr, o_bus_wdata, o_bus_mask);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_load();
    int c;
    run_load(32'h0000_1000, 32'hDEAD_BEEF, c);
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_rsp_valid, o_req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL load_idle busy/rsp_valid/ready got=%b expected=001", {o_busy, o_rsp_valid, o_req_ready});
    end
  endtask

  task automatic test_store_stall();
    @(negedge i_clk);
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    drive_req(32'h0000_2000, 1'b1, 32'hAB00_0000, 4'b1000);
    @(negedge i_clk);
    // Scramble the request inputs to show the bus side is fed from the captured copy.
    i_req_valid = 1'b0;
    i_req_addr  = 32'hFFFF_FFFF;
    i_req_wen   = 1'b0;
    i_req_wdata = 32'h5555_5555;
    i_req_mask  = 4'hF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_bus_req_valid !== 1'b1 || o_bus_addr !== 32'h0000_2000 || o_bus_wen !== 1'b1 ||
          o_bus_wdata !== 32'hAB00_0000 || o_bus_mask !== 4'b1000) begin
        errors++;
        $display("FAIL store_bus_stable cycle=%0d valid=%b addr=%h wen=%b wdata=%h mask=%b expected 1 00002000 1 ab000000 1000",
                 i, o_bus_req_valid, o_bus_addr, o_bus_wen, o_bus_wdata, o_bus_mask);
      end
      if (i == 3) i_bus_req_ready = 1'b1;
      @(negedge i_clk);
    end
    release_req();
    i_bus_req_ready = 1'b0;
    checks++;
    if ({o_bus_req_valid, o_busy, o_rsp_valid} !== 3'b010) begin
      errors++;
      $display("FAIL store_wait req_valid/busy/rsp_valid got=%b expected=010", {o_bus_req_valid, o_busy, o_rsp_valid});
    end
    i_bus_rsp_valid = 1'b1;
    i_bus_rsp_rdata = 32'h1234_5678;
    @(negedge i_clk);
    i_bus_rsp_valid = 1'b0;
    i_bus_rsp_rdata = '0;
    checks++;
    if (o_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL store_rsp_timing got=%b expected=1", o_rsp_valid);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs[3] = '{32'h0000_1002, 32'h0000_1001, 32'h0000_3000};
    logic [3:0]  masks[3] = '{4'hF, 4'hF, 4'h0};
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      sb_q.push_back('{rdata: 32'h0, err: 1'b1});
      drive_req(addrs[i], 1'b0, 32'h0, masks[i]);
      @(negedge i_clk);
      release_req();
      checks++;
      if ({o_rsp_valid, o_rsp_err, o_bus_req_valid} !== 3'b110) begin
        errors++;
        $display("FAIL misaligned_rsp addr=%h mask=%h rsp_valid/err/bus_valid got=%b expected=110",
                 addrs[i], masks[i], {o_rsp_valid, o_rsp_err, o_bus_req_valid});
      end
      @(negedge i_clk);
      checks++;
      if ({o_rsp_valid, o_bus_req_valid, o_busy} !== 3'b000) begin
        errors++;
        $display("FAIL misaligned_after addr=%h rsp_valid/bus_valid/busy got=%b expected=000",
                 addrs[i], {o_rsp_valid, o_bus_req_valid, o_busy});
      end
    end
  endtask

  task automatic test_timeout();
    @(negedge i_clk);
    sb_q.push_back('{rdata: 32'h0, err: 1'b1});
    drive_req(32'h0000_4000, 1'b0, 32'h0, 4'hF);
    @(negedge i_clk);
    release_req();
    i_bus_req_ready = 1'b1;
    @(negedge i_clk);
    i_bus_req_ready = 1'b0;
    for (int k = 0; k < int'(TB_TIMEOUT); k++) begin
      checks++;
      if (o_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early wait_cycle=%0d rsp_valid got=%b expected=0", k, o_rsp_valid);
      end
      @(negedge i_clk);
    end
    checks++;
    if ({o_rsp_valid, o_rsp_err} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_rsp rsp_valid/err got=%b expected=11", {o_rsp_valid, o_rsp_err});
    end
    @(negedge i_clk);
    checks++;
    if ({o_req_ready, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_stale ready/busy got=%b expected=00", {o_req_ready, o_busy});
    end
    drive_req(32'h0000_5000, 1'b0, 32'h0, 4'hF);
    @(negedge i_clk);
    checks++;
    if ({o_req_ready, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_hold ready/busy got=%b expected=00", {o_req_ready, o_busy});
    end
    i_bus_rsp_valid = 1'b1;
    i_bus_rsp_rdata = 32'hBAD0_BAD0;
    @(negedge i_clk);
    i_bus_rsp_valid = 1'b0;
    i_bus_rsp_rdata = '0;
    checks++;
    if ({o_rsp_valid, o_req_ready, o_busy} !== 3'b010) begin
      errors++;
      $display("FAIL timeout_late_drop rsp_valid/ready/busy got=%b expected=010",
               {o_rsp_valid, o_req_ready, o_busy});
    end
    sb_q.push_back('{rdata: 32'h5555_AAAA, err: 1'b0});
    @(negedge i_clk);
    release_req();
    checks++;
    if (o_bus_req_valid !== 1'b1 || o_bus_addr !== 32'h0000_5000) begin
      errors++;
      $display("FAIL timeout_held_req valid=%b addr=%h expected 1 00005000", o_bus_req_valid, o_bus_addr);
    end
    i_bus_req_ready = 1'b1;
    @(negedge i_clk);
    i_bus_req_ready = 1'b0;
    i_bus_rsp_valid = 1'b1;
    i_bus_rsp_rdata = 32'h5555_AAAA;
    @(negedge i_clk);
    i_bus_rsp_valid = 1'b0;
    i_bus_rsp_rdata = '0;
    checks++;
    if (o_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_held_rsp got=%b expected=1", o_rsp_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    int c;
    @(negedge i_clk);
    drive_req(32'h0000_6000, 1'b1, 32'hCAFE_F00D, 4'hF);
    @(negedge i_clk);
    release_req();
    i_bus_req_ready = 1'b1;
    @(negedge i_clk);
    i_bus_req_ready = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_bus_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_pre busy/req_valid got=%b expected=10", {o_busy, o_bus_req_valid});
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checks++;
    if ({o_req_ready, o_busy, o_rsp_valid, o_bus_req_valid, o_bus_wen} !== 5'b10000 ||
        o_bus_addr !== '0 || o_bus_wdata !== '0 || o_bus_mask !== '0) begin
      errors++;
      $display("FAIL rst_wait_post ctrl=%b addr=%h wdata=%h mask=%h expected 10000 and zero bus",
               {o_req_ready, o_busy, o_rsp_valid, o_bus_req_valid, o_bus_wen}, o_bus_addr, o_bus_wdata, o_bus_mask);
    end
    run_load(32'h0000_7000, 32'h0BAD_F00D, c);
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    run_load(32'h0000_8000, 32'h1111_1111, c1);
    run_load(32'h0000_8004, 32'h2222_2222, c2);
    checks++;
    if (c2 - c1 != 4) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d expected=4", c2 - c1);
    end
  endtask

  initial begin
    i_rst           = 1'b1;
    i_bus_req_ready = 1'b0;
    i_bus_rsp_valid = 1'b0;
    i_bus_rsp_rdata = '0;
    release_req();

    test_reset();
    test_load();
    test_store_stall();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();

    repeat (2) @(negedge i_clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain outstanding=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Multi-cycle data-memory controller that sits directly downstream of the hart's memory stage. It replaces today's combinational dmem port with a realistic request/response bus. It accepts one word-aligned load or store from the memory stage over a valid/ready handshake, issues it to the memory bus, waits for the bus response, and returns read data or a store acknowledgement. Alignment errors and bus timeouts are reported as a trap-qualifying error.

## Interface
- `TIMEOUT`, default 64: cycles allowed in WAIT before an error response is returned; legal range 2..65535.
- `i_clk` in 1: single clock; everything is on its rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_req_valid` in 1: memory stage presents a request.
- `o_req_ready` out 1: controller accepts a request.
- `i_req_addr` in 32: byte address, expected 4-byte aligned.
- `i_req_wen` in 1: 1 = store, 0 = load.
- `i_req_wdata` in 32: store data, already lane-shifted.
- `i_req_mask` in 4: byte-lane mask.
- `o_rsp_valid` out 1: one-cycle response pulse.
- `o_rsp_rdata` out 32: load data; 0 for stores and errors.
- `o_rsp_err` out 1: qualifies `o_rsp_valid`; misaligned access or timeout.
- `o_busy` out 1: high whenever state ≠ IDLE; the hart uses it as a stall.
- `o_bus_req_valid` out 1: bus request valid.
- `i_bus_req_ready` in 1: bus accepts the request.
- `o_bus_addr` out 32: registered copy of the request address.
- `o_bus_wen` out 1: registered copy of `i_req_wen`.
- `o_bus_wdata` out 32: registered copy of `i_req_wdata`.
- `o_bus_mask` out 4: registered copy of `i_req_mask`.
- `i_bus_rsp_valid` in 1: bus response; returned for stores as well as loads.
- `i_bus_rsp_rdata` in 32: bus read data.

## Operation
- **States:**
  - IDLE → REQ on an accepted request with `addr[1:0]==0` and `mask≠0`.
  - IDLE → RESP (error) on an accepted request with misaligned address or `mask==0`. No bus traffic is generated.
  - REQ → WAIT on the `o_bus_req_valid && i_bus_req_ready` handshake.
  - WAIT → RESP on `i_bus_rsp_valid`: capture rdata, or force it to 0 for stores; err=0.
  - WAIT → RESP on timeout: counter reaches `TIMEOUT-1`; err=1, rdata=0; set `stale`.
  - RESP → IDLE unconditionally.
- `o_req_ready = (state==IDLE) && !stale`.
- The request is registered on acceptance. Bus outputs come from those registers and stay stable while `o_bus_req_valid` is high.
- **Timeout counter:**
  - 16-bit, cleared when entering WAIT, increments each WAIT cycle.
  - Saturating is not needed because it exits at `TIMEOUT-1`.
- **`stale` flag:**
  - Set on timeout.
  - Cleared by the next `i_bus_rsp_valid`; that response is discarded.
  - While `stale` is set, no new request is accepted.
- `i_bus_rsp_valid` outside WAIT and not stale is ignored.
- A request arriving while `o_req_ready=0` is not accepted. The requester holds it.

## Timing
- **Reset values:** state=IDLE, `stale`=0, counter=0, `o_req_ready`=1, and every other output 0, including the bus address/data registers.
- Reset asserted mid-transaction forces IDLE on the next edge. Any in-flight bus response after reset is not tracked.
- **Minimum load/store latency,** request accepted at cycle N:
  - `o_bus_req_valid` high in N+1.
  - Bus ready in N+1, so WAIT in N+2.
  - Bus response in N+2, so `o_rsp_valid` in N+3.
- The bus never responds in the same cycle as its request handshake.
- Misaligned request accepted at N: `o_rsp_valid=1, o_rsp_err=1` in N+1.
- Timeout with WAIT entered at W: `o_rsp_valid` with err in W+TIMEOUT.
- `o_rsp_valid` is high for exactly one cycle. A back-to-back request can be accepted in the cycle after RESP.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE, REQ, WAIT, RESP);
  - `TIMEOUT_W=16`;
  - a mask-legality constant (no zero mask).
- One natural sub-module, `dmem_timeout_ctr`: clear, enable, terminal-count compare against `TIMEOUT-1`.
- FSM and capture registers stay in `dmem_ctrl`.

## Test plan
- **Load, zero-wait bus:** req addr=0x1000, wen=0, mask=1111 at N; bus ready N+1; rsp rdata=0xDEADBEEF at N+2.
  - Expect `o_rsp_valid=1`, rdata=0xDEADBEEF, err=0 at N+3.
  - Expect `o_busy` high N+1..N+3.
- **Byte store, bus ready withheld 3 cycles:** addr=0x2000, mask=1000, wdata=0xAB000000.
  - Bus outputs stay stable throughout.
  - Response has rdata=0 and err=0 one cycle after the bus ack.
- **Misaligned request:** addr=0x1002, mask=1111.
  - Expect an error response at N+1.
  - `o_bus_req_valid` never asserts.
- **Timeout, TIMEOUT=4:** no bus response.
  - Expect err=1 exactly 4 cycles after WAIT entry.
  - Expect `o_req_ready=0` until a late bus response arrives; that response is dropped with no `o_rsp_valid`.
- **Reset in WAIT:** assert `i_rst` for one cycle.
  - Next cycle: state IDLE, `o_req_ready=1`, all bus outputs 0.
  - A new load then completes normally.
- **Back-to-back loads with zero-wait bus:** second request accepted the cycle after the first `o_rsp_valid`; responses spaced 4 cycles apart.
